// File: rtl/smvm_pkg.sv
// Shared types and constants for the SpMV result path.
package smvm_pkg;

  localparam int HALF_W   = 14;
  localparam int RESULT_W = 28;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DRAIN,
    S_DONE
  } state_t;

  // Pure concatenation: the core already produced a 28-bit two's complement value.
  function automatic logic [RESULT_W-1:0] join_halves(input logic [HALF_W-1:0] hi,
                                                      input logic [HALF_W-1:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/smvm_result_collector_if.sv
// Core half-word stream in, tagged result valid/ready stream out.
interface smvm_result_collector_if #(parameter int ROW_W = 7);

  logic                           in_valid;
  logic [smvm_pkg::HALF_W-1:0]    in_data;
  logic                           out_valid;
  logic                           out_ready;
  logic [smvm_pkg::RESULT_W-1:0]  out_data;
  logic [ROW_W-1:0]               out_row;

  // master: the collector; slave: core driver plus host consumer
  modport master (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data, out_row
  );

  modport slave (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data, out_row
  );

endinterface

// File: rtl/smvm_sync_fifo.sv
// Synchronous FIFO with register-array storage; head visible the cycle after push.
// Full push is dropped unless a pop happens in the same cycle.
module smvm_sync_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty,
  output logic             last
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign last     = ((wr_ptr - rd_ptr) == PTR_ONE);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign head_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_dat;
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/smvm_result_collector.sv
// Reassembles hi/lo half-words into tagged 28-bit row results, buffers them, and
// streams them out on valid/ready; done once every configured row has been delivered.
module smvm_result_collector
  import smvm_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int ROW_W = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_load,
  input  logic [ROW_W:0]        cfg_rows,
  smvm_result_collector_if.master bus,
  output logic                  done,
  output logic                  err
);

  localparam int          ENTRY_W = ROW_W + RESULT_W;
  localparam logic [ROW_W:0] ROW_ONE = {{ROW_W{1'b0}}, 1'b1};

  state_t             state;
  logic               phase;
  logic [HALF_W-1:0]  hi_q;
  logic [ROW_W:0]     row_cnt;
  logic [ROW_W:0]     rows_q;
  logic [ROW_W:0]     row_nxt;

  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_last;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] push_dat;
  logic [ENTRY_W-1:0] head_dat;

  assign row_nxt  = row_cnt + ROW_ONE;
  assign pop      = bus.out_valid && bus.out_ready;
  assign push     = (state == S_COLLECT) && bus.in_valid && phase && !cfg_load;
  assign push_dat = {row_cnt[ROW_W-1:0], join_halves(hi_q, bus.in_data)};

  assign bus.out_valid               = !fifo_empty;
  assign {bus.out_row, bus.out_data} = head_dat;

  smvm_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (cfg_load),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head_dat (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .last     (fifo_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      phase   <= 1'b0;
      hi_q    <= '0;
      row_cnt <= '0;
      rows_q  <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else if (cfg_load) begin
      rows_q  <= cfg_rows;
      phase   <= 1'b0;
      row_cnt <= '0;
      err     <= 1'b0;
      if (cfg_rows == '0) begin
        state <= S_DONE;
        done  <= 1'b1;
      end else begin
        state <= S_COLLECT;
        done  <= 1'b0;
      end
    end else begin
      case (state)
        S_IDLE: begin
        end
        S_COLLECT: begin
          if (bus.in_valid) begin
            if (!phase) begin
              hi_q  <= bus.in_data;
              phase <= 1'b1;
            end else begin
              phase   <= 1'b0;
              row_cnt <= row_nxt;
              // Dropped result still counts, so the job can finish.
              if (fifo_full && !pop) begin
                err <= 1'b1;
              end
              if (row_nxt == rows_q) begin
                state <= S_DRAIN;
              end
            end
          end
        end
        S_DRAIN: begin
          if (bus.in_valid) begin
            err <= 1'b1;
          end
          if (fifo_empty || (fifo_last && pop)) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          if (bus.in_valid) begin
            err <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_smvm_result_collector.sv
// Scoreboard bench for smvm_result_collector: directed half-word streams in,
// monitor pops expected (row, data) pairs on every accepted output beat.
module tb_smvm_result_collector;

  localparam int ROW_W = 7;
  localparam int DEPTH = 8;

  typedef struct {
    logic [27:0]      data;
    logic [ROW_W-1:0] row;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cfg_load = 1'b0;
  logic [ROW_W:0] cfg_rows = '0;
  logic           done;
  logic           err;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   exp_row  = 0;
  exp_t exp_q[$];

  smvm_result_collector_if #(.ROW_W(ROW_W)) bus ();

  smvm_result_collector #(.DEPTH(DEPTH), .ROW_W(ROW_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_load (cfg_load),
    .cfg_rows (cfg_rows),
    .bus      (bus),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [13:0] half);
    bus.in_valid = 1'b1;
    bus.in_data  = half;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic send_row(input logic [13:0] hi, input logic [13:0] lo, input bit exp_push);
    exp_t e;
    send(hi);
    if (exp_push) begin
      e.data = {hi, lo};
      e.row  = exp_row[ROW_W-1:0];
      exp_q.push_back(e);
    end
    exp_row++;
    send(lo);
  endtask

  task automatic cfg(input int rows);
    cfg_load = 1'b1;
    cfg_rows = rows[ROW_W:0];
    tick();
    cfg_load = 1'b0;
    exp_row  = 0;
    exp_q.delete();
  endtask

  task automatic wait_done(input string name, input int budget);
    for (int i = 0; i < budget && !done; i++) tick();
    check(name, 32'(done), 32'd1);
  endtask

  task automatic wait_empty(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: every accepted beat must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_output: got row %0d data 0x%0h, expected no output",
                 bus.out_row, bus.out_data);
      end else begin
        e = exp_q.pop_front();
        check("out_data", 32'(bus.out_data), 32'(e.data));
        check("out_row", 32'(bus.out_row), 32'(e.row));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_out_row", 32'(bus.out_row), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    tick();

    // Basic two-row job, consumer always ready
    bus.out_ready = 1'b1;
    cfg(2);
    send_row(14'h0000, 14'h0005, 1'b1);
    send_row(14'h3FFF, 14'h3FFE, 1'b1);
    tick();
    check("basic_done_timing", 32'(done), 32'd1);
    check("basic_err", 32'(err), 32'd0);
    wait_empty("basic_drained", 10);

    // Gapped halves
    cfg(1);
    check("cfg_clears_done", 32'(done), 32'd0);
    send(14'h0001);
    repeat (3) tick();
    begin
      exp_t e;
      e.data = 28'h0006000;
      e.row  = '0;
      exp_q.push_back(e);
      exp_row++;
    end
    send(14'h2000);
    wait_done("gap_done", 10);
    check("gap_err", 32'(err), 32'd0);

    // Backpressure and overflow: ninth row is dropped
    bus.out_ready = 1'b0;
    cfg(9);
    for (int i = 0; i < 9; i++) send_row(14'(i), 14'(16'h0100 + i), i < 8);
    check("ovf_err", 32'(err), 32'd1);
    check("ovf_out_valid", 32'(bus.out_valid), 32'd1);
    check("ovf_done_held", 32'(done), 32'd0);
    bus.out_ready = 1'b1;
    wait_done("ovf_done", 40);
    check("ovf_err_sticky", 32'(err), 32'd1);
    check("ovf_drained", 32'(exp_q.size()), 32'd0);

    // Full FIFO with push and pop in the same cycle
    bus.out_ready = 1'b0;
    cfg(10);
    for (int i = 0; i < 8; i++) send_row(14'(16'h0200 + i), 14'(16'h0300 + i), 1'b1);
    send(14'h0AAA);
    begin
      exp_t e;
      e.data = {14'h0AAA, 14'h1555};
      e.row  = exp_row[ROW_W-1:0];
      exp_q.push_back(e);
      exp_row++;
    end
    bus.in_valid  = 1'b1;
    bus.in_data   = 14'h1555;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("pushpop_no_err", 32'(err), 32'd0);
    // Still full: one more result without a pop must overflow
    send_row(14'h0111, 14'h0222, 1'b0);
    check("pushpop_still_full", 32'(err), 32'd1);
    bus.out_ready = 1'b1;
    wait_done("pushpop_done", 40);
    check("pushpop_drained", 32'(exp_q.size()), 32'd0);

    // Zero-row job
    cfg(0);
    check("zero_done", 32'(done), 32'd1);
    check("zero_err_clear", 32'(err), 32'd0);
    send(14'h0123);
    check("zero_excess_err", 32'(err), 32'd1);

    // Abort by cfg_load after three buffered rows
    bus.out_ready = 1'b0;
    cfg(5);
    check("abort_err_clear", 32'(err), 32'd0);
    check("abort_done_clear", 32'(done), 32'd0);
    for (int i = 0; i < 3; i++) send_row(14'(16'h0040 + i), 14'(16'h0050 + i), 1'b1);
    check("abort_buffered", 32'(bus.out_valid), 32'd1);
    cfg(4);
    check("abort_cfg_flush", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b1;
    send_row(14'h0AAA, 14'h0555, 1'b1);
    wait_empty("abort_cfg_restart", 10);

    // Abort by reset with results buffered
    bus.out_ready = 1'b0;
    send_row(14'h0001, 14'h0002, 1'b1);
    send_row(14'h0003, 14'h0004, 1'b1);
    check("rst_abort_buffered", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    tick();
    exp_q.delete();
    check("rst_abort_valid", 32'(bus.out_valid), 32'd0);
    check("rst_abort_done", 32'(done), 32'd0);
    check("rst_abort_err", 32'(err), 32'd0);
    rst = 1'b0;
    tick();
    bus.out_ready = 1'b1;
    cfg(1);
    send_row(14'h2345, 14'h0678, 1'b1);
    wait_done("rst_abort_restart", 10);

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/smvm_result_collector.md
# smvm_result_collector

Downstream stage of the sparse matrix-vector multiply core. It consumes the core's serial 14-bit output stream, which carries each 28-bit signed row result as a high half followed by a low half. It reassembles each row result, tags it with its row index and buffers it in a small FIFO. It then presents the results on a valid/ready stream to the host side, and signals completion once all configured rows have been delivered.

## Interface
Parameters:
- DEPTH, 8: result FIFO entries, power of two, ≥ 2.
- ROW_W, 7: row-index width; supports up to 2^ROW_W rows.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cfg_load  in  1  one-cycle pulse; latches cfg_rows and starts a job.
- cfg_rows  in  ROW_W+1  number of row results expected this job (0..2^ROW_W).
- in_valid  in  1  core output valid; no backpressure upstream.
- in_data  in  14  core output half-word.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head when out_valid & out_ready.
- out_data  out  28  reassembled signed row result.
- out_row  out  ROW_W  row index of out_data, 0-based, in arrival order.
- done  out  1  level; high from job completion until next cfg_load or rst.
- err  out  1  sticky; set on FIFO overflow or excess input; cleared only by cfg_load or rst.

## Operation
- States: IDLE, COLLECT, DRAIN, DONE.
- IDLE: input ignored. cfg_load → COLLECT, or → DONE when cfg_rows = 0.
- COLLECT: half-phase bit. Phase 0 with in_valid captures in_data as result[27:14]. Phase 1 with in_valid forms {hi, in_data} and pushes it with the current row tag; row_cnt increments. Gaps in in_valid between halves are allowed; the hi half is held.
- When the pushed result is row cfg_rows-1 → DRAIN.
- DRAIN: input ignored; any in_valid sets err. FIFO empty → DONE.
- DONE: done = 1; in_valid sets err. cfg_load → restart as from IDLE.
- cfg_load in any state: flushes FIFO, clears phase, row_cnt, err and done, then enters COLLECT (or DONE when cfg_rows = 0).
- Overflow: a push arriving when the FIFO is full with no same-cycle pop drops the result and sets err. row_cnt still increments, so the job still completes.
- Full FIFO with simultaneous push and pop: both succeed; occupancy is unchanged.
- Arithmetic: pure concatenation, no sign extension or rounding. out_data is 28-bit two's complement as produced by the core.
- row_cnt is ROW_W+1 bits wide, and out_row = row_cnt[ROW_W-1:0] at push time.

## Timing
- Reset values: out_valid 0, out_data 0, out_row 0, done 0, err 0. State is IDLE, FIFO empty, phase 0, row_cnt 0.
- Latency: a result pushed on the edge that samples its low half shows out_valid = 1 in the following cycle.
- Throughput: one result per two input cycles in; one result per cycle out.
- out_data and out_row are stable while out_valid & !out_ready.
- FIFO pointers wrap modulo DEPTH. Full and empty are distinguished by an extra pointer bit.
- done rises in the cycle after the last pop in DRAIN, or the cycle after cfg_load when cfg_rows = 0.
- rst mid-job aborts immediately, and all buffered results are lost.

## Structure
- Shared package smvm_pkg holds the state encoding (IDLE/COLLECT/DRAIN/DONE) and the constants HALF_W = 14 and RESULT_W = 28.
- One sub-module, smvm_sync_fifo: parameterised width and depth, registered head, push/pop/full/empty, with a synchronous flush input.
- The FSM, phase bit, row counter and error logic are top-level.

## Test plan
- Basic: cfg_rows = 2. Input stream 0x0000, 0x0005, 0x3FFF, 0x3FFE, with out_ready held 1. Expect (row 0, 0x0000005), then (row 1, 0xFFFFFFE = -2); done rises after the second pop.
- Gapped halves: hi 0x0001, three idle cycles, lo 0x2000. Expect a single result 0x0006000.
- Backpressure and overflow: DEPTH = 8, out_ready = 0, feed 9 rows. Expect rows 0..7 buffered and err = 1. Release out_ready: rows 0..7 drain in order, and done = 1 after the 8th pop.
- Full with simultaneous push and pop: hold the FIFO full and pulse out_ready exactly when a low half arrives. Expect no err and occupancy still 8.
- cfg_rows = 0: cfg_load → done = 1 next cycle. A later in_valid sets err.
- Mid-job abort: assert rst, or issue cfg_load after 3 rows are buffered. Expect out_valid = 0 next cycle, err and done cleared, and row tags restarting at 0.
